// File: rtl/uart_pkg.sv
// Shared UART definitions: divisor type, standard baud rates and divisor helpers.
package uart_pkg;

   localparam int unsigned DIV_INT_W  = 16;
   localparam int unsigned DIV_FRAC_W = 4;

   localparam int unsigned BAUD_1200   = 1200;
   localparam int unsigned BAUD_19200  = 19200;
   localparam int unsigned BAUD_57600  = 57600;
   localparam int unsigned BAUD_115200 = 115200;

   typedef struct packed {
      logic [DIV_INT_W-1:0]  div_int;
      logic [DIV_FRAC_W-1:0] div_frac;
   } uart_div_t;

   // Divisor for an arbitrary baud rate, fraction rounded down to 1/2^DIV_FRAC_W.
   function automatic uart_div_t uart_baud_div(input int unsigned clk_hz,
                                               input int unsigned ovs,
                                               input int unsigned baud);
      uart_div_t   d;
      longint unsigned scaled;
      scaled     = (longint'(clk_hz) << DIV_FRAC_W) / (longint'(ovs) * longint'(baud));
      d.div_int  = DIV_INT_W'(scaled >> DIV_FRAC_W);
      d.div_frac = DIV_FRAC_W'(scaled);
      return d;
   endfunction

   // Power-up divisor: integer part of the 115200 divisor only.
   function automatic uart_div_t uart_default_div(input int unsigned clk_hz,
                                                  input int unsigned ovs);
      uart_div_t d;
      d          = uart_baud_div(clk_hz, ovs, BAUD_115200);
      d.div_frac = '0;
      return d;
   endfunction

endpackage

// File: rtl/baud_frac_div.sv
// Tick counter, fractional accumulator and oversample phase.
// Fractional accumulator present only when BAUD_FRAC_GEN_FRAC_EN is defined.
module baud_frac_div #(
   parameter int Oversample = 16,
   parameter int DivWidth   = 16,
   parameter int FracWidth  = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 en_i,
   input  logic                 sync_i,
   input  logic                 clr_i,
   input  logic [DivWidth-1:0]  div_int_i,
   input  logic [FracWidth-1:0] div_frac_i,
   output logic                 tick_o,
   output logic                 bit_tick_o
);

   localparam int PhW = $clog2(Oversample);

   logic [DivWidth-1:0] r_count;
   logic [PhW-1:0]      r_phase;
   logic [DivWidth-1:0] w_limit;
   logic                w_restart;

`ifdef BAUD_FRAC_GEN_FRAC_EN
   logic [FracWidth-1:0] r_acc;
   logic                 r_extra;
   logic [FracWidth:0]   w_acc_sum;

   assign w_acc_sum = {1'b0, r_acc} + {1'b0, div_frac_i};
   // A carry out of the accumulator stretches the following period by one cycle.
   assign w_limit   = div_int_i - DivWidth'(1) + DivWidth'(r_extra);

   always_ff @(posedge clk_i) begin
      if (!rst_ni || w_restart) begin
         r_acc   <= '0;
         r_extra <= 1'b0;
      end else if (tick_o) begin
         {r_extra, r_acc} <= w_acc_sum;
      end
   end
`else
   logic w_unused_frac;
   assign w_unused_frac = ^div_frac_i;
   assign w_limit       = div_int_i - DivWidth'(1);
`endif

   assign w_restart  = ~en_i | sync_i | clr_i;
   assign tick_o     = rst_ni & en_i & ~sync_i & (r_count == w_limit);
   assign bit_tick_o = tick_o & (r_phase == PhW'(Oversample - 1));

   always_ff @(posedge clk_i) begin
      if (!rst_ni || w_restart) begin
         r_count <= '0;
         r_phase <= '0;
      end else if (tick_o) begin
         r_count <= '0;
         r_phase <= r_phase + PhW'(1);
      end else begin
         r_count <= r_count + DivWidth'(1);
      end
   end

endmodule

// File: rtl/baud_frac_gen.sv
// Fractional baud generator top: divisor staging and deferred apply around baud_frac_div.
// Define BAUD_FRAC_GEN_FRAC_EN to enable the fractional divisor.
module baud_frac_gen
   import uart_pkg::*;
#(
   parameter int ClockFrequency = 50_000_000,
   parameter int Oversample     = 16,
   parameter int DivWidth       = 16,
   parameter int FracWidth      = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 en_i,
   input  logic                 sync_i,
   input  logic                 busy_i,
   input  logic                 div_wr_i,
   input  logic [DivWidth-1:0]  div_int_i,
   input  logic [FracWidth-1:0] div_frac_i,
   output logic                 div_pending_o,
   output logic                 tick_o,
   output logic                 bit_tick_o
);

   localparam uart_div_t DefDiv = uart_default_div(ClockFrequency, Oversample);

   logic [DivWidth-1:0]  r_stg_int,  r_act_int;
   logic [FracWidth-1:0] r_stg_frac, r_act_frac;
   logic                 r_pending;
   logic [DivWidth-1:0]  w_wr_int;
   logic                 w_tick;
   logic                 w_apply;

   assign w_wr_int = (div_int_i < DivWidth'(2)) ? DivWidth'(2) : div_int_i;
   // Swap only on a period boundary outside a frame, or at once while idle.
   assign w_apply  = r_pending & ((w_tick & ~busy_i) | ~en_i);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_act_int  <= DivWidth'(DefDiv.div_int);
         r_act_frac <= FracWidth'(DefDiv.div_frac);
         r_stg_int  <= '0;
         r_stg_frac <= '0;
         r_pending  <= 1'b0;
      end else begin
         if (w_apply) begin
            r_act_int  <= r_stg_int;
            r_act_frac <= r_stg_frac;
         end
         if (div_wr_i) begin
            r_stg_int  <= w_wr_int;
            r_stg_frac <= div_frac_i;
            r_pending  <= 1'b1;
         end else if (w_apply) begin
            r_pending  <= 1'b0;
         end
      end
   end

   baud_frac_div #(
      .Oversample (Oversample),
      .DivWidth   (DivWidth),
      .FracWidth  (FracWidth)
   ) u_div (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .en_i       (en_i),
      .sync_i     (sync_i),
      .clr_i      (w_apply),
      .div_int_i  (r_act_int),
      .div_frac_i (r_act_frac),
      .tick_o     (w_tick),
      .bit_tick_o (bit_tick_o)
   );

   assign tick_o        = w_tick;
   assign div_pending_o = r_pending;

endmodule

// File: tb/tb_baud_frac_gen.sv
// Self-checking bench for baud_frac_gen: directed scenarios plus random traffic vs. an arithmetic tick-time model.
module tb_baud_frac_gen;

   localparam int OVS = 16;
   localparam int FW  = 4;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        en_i = 1'b0;
   logic        sync_i = 1'b0;
   logic        busy_i = 1'b0;
   logic        div_wr_i = 1'b0;
   logic [15:0] div_int_i = '0;
   logic [3:0]  div_frac_i = '0;
   logic        div_pending_o, tick_o, bit_tick_o;

   baud_frac_gen dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .sync_i(sync_i), .busy_i(busy_i),
      .div_wr_i(div_wr_i), .div_int_i(div_int_i), .div_frac_i(div_frac_i),
      .div_pending_o(div_pending_o), .tick_o(tick_o), .bit_tick_o(bit_tick_o)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;

   // Reference state: active/staged divisor, counting cycles and ticks since last restart.
   int m_act = 27, m_actf = 0, m_stg = 0, m_stgf = 0;
   bit m_pend = 1'b0;
   int m_cyc = 0, m_n = 0;
   int cyc_no = 0;
   int tick_q[$];
   int bit_q[$];

   // 1-based counting-cycle index of the k-th tick after a restart.
   function automatic int tick_time(int k, int d, int f);
`ifdef BAUD_FRAC_GEN_FRAC_EN
      return k * d + ((k - 1) * f) / (1 << FW);
`else
      return k * d + 0 * f;
`endif
   endfunction

   function automatic int tgap(int i, int j);
      if (tick_q.size() <= j) return -1;
      return tick_q[j] - tick_q[i];
   endfunction

   task automatic chk(string tag, int obs, int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d cycle=%0d", tag, obs, exp, cyc_no);
      end
   endtask

   task automatic step();
      bit e_tick, e_bit, apply;
      #1;
      e_tick = rst_ni && en_i && !sync_i && (m_cyc + 1 == tick_time(m_n + 1, m_act, m_actf));
      e_bit  = e_tick && ((m_n + 1) % OVS == 0);
      chk("tick", int'(tick_o), int'(e_tick));
      chk("bit_tick", int'(bit_tick_o), int'(e_bit));
      chk("pending", int'(div_pending_o), int'(m_pend));
      if (tick_o) tick_q.push_back(cyc_no);
      if (bit_tick_o) bit_q.push_back(cyc_no);
      @(posedge clk_i);
      if (!rst_ni) begin
         m_act = 27; m_actf = 0; m_stg = 0; m_stgf = 0; m_pend = 1'b0;
         m_cyc = 0; m_n = 0;
      end else begin
         apply = m_pend && ((e_tick && !busy_i) || !en_i);
         if (apply) begin m_act = m_stg; m_actf = m_stgf; end
         if (div_wr_i) begin
            m_stg  = (div_int_i < 2) ? 2 : int'(div_int_i);
            m_stgf = int'(div_frac_i);
            m_pend = 1'b1;
         end else if (apply) m_pend = 1'b0;
         if (!en_i || sync_i || apply) begin m_cyc = 0; m_n = 0; end
         else begin m_cyc++; if (e_tick) m_n++; end
      end
      cyc_no++;
      @(negedge clk_i);
   endtask

   task automatic run(int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Load a divisor while disabled so it applies immediately.
   task automatic load(int d, int f);
      en_i = 1'b0; busy_i = 1'b0;
      div_wr_i = 1'b1; div_int_i = 16'(d); div_frac_i = 4'(f);
      step();
      div_wr_i = 1'b0;
      step();
   endtask

   int t0;

   initial begin
      @(negedge clk_i);
      // reset state
      run(2);
      rst_ni = 1'b1;
      run(1);
      chk("rst_pending", int'(div_pending_o), 0);

      // default divisor: first tick in the 27th enabled cycle
      en_i = 1'b1; tick_q.delete(); t0 = cyc_no;
      run(60);
      chk("first_tick", (tick_q.size() > 0) ? tick_q[0] - t0 : -1, 26);
      chk("default_period", tgap(0, 1), 27);

      // fractional 27 + 2/16: any 8 consecutive periods span 217 cycles
      load(27, 2);
      en_i = 1'b1; tick_q.delete();
      run(9 * 28 + 5);
`ifdef BAUD_FRAC_GEN_FRAC_EN
      chk("frac_8_periods", tgap(0, 8), 217);
`else
      chk("frac_8_periods", tgap(0, 8), 216);
`endif

      // div 4, oversample 16: bit tick every 64 cycles
      load(4, 0);
      en_i = 1'b1; bit_q.delete();
      run(140);
      chk("bit_tick_period", (bit_q.size() > 1) ? bit_q[1] - bit_q[0] : -1, 64);

      // div 1 clamps to 2
      load(1, 0);
      en_i = 1'b1; tick_q.delete();
      run(10);
      chk("clamp_period", tgap(0, 1), 2);

      // write while busy is deferred; applies on the first tick after busy drops
      load(27, 0);
      en_i = 1'b1; busy_i = 1'b1;
      run(30);
      div_wr_i = 1'b1; div_int_i = 16'd10; div_frac_i = '0;
      step();
      div_wr_i = 1'b0; tick_q.delete();
      run(60);
      chk("busy_pending", int'(div_pending_o), 1);
      chk("busy_old_period", tgap(0, 1), 27);
      busy_i = 1'b0; tick_q.delete();
      run(40);
      chk("applied_period", tgap(1, 2), 10);
      chk("applied_pending", int'(div_pending_o), 0);

      // sync at count 5 of a 27-cycle period
      load(27, 0);
      en_i = 1'b1;
      run(32);
      sync_i = 1'b1; t0 = cyc_no;
      step();
      sync_i = 1'b0; tick_q.delete();
      run(30);
      chk("sync_next_tick", (tick_q.size() > 0) ? tick_q[0] - t0 : -1, 27);

      // reset with a staged write pending
      busy_i = 1'b1;
      div_wr_i = 1'b1; div_int_i = 16'd10;
      step();
      div_wr_i = 1'b0;
      run(3);
      chk("staged_pending", int'(div_pending_o), 1);
      rst_ni = 1'b0;
      step();
      rst_ni = 1'b1; busy_i = 1'b0; t0 = cyc_no; tick_q.delete();
      chk("rst_clears_pending", int'(div_pending_o), 0);
      run(60);
      chk("rst_first_tick", (tick_q.size() > 0) ? tick_q[0] - t0 : -1, 26);
      chk("rst_default_period", tgap(0, 1), 27);

      // random traffic against the model
      for (int i = 0; i < 4000; i++) begin
         rst_ni     = ($urandom_range(0, 399) != 0);
         en_i       = ($urandom_range(0, 29) != 0);
         sync_i     = ($urandom_range(0, 79) == 0);
         busy_i     = $urandom_range(0, 1);
         div_wr_i   = ($urandom_range(0, 49) == 0);
         div_int_i  = 16'($urandom_range(0, 12));
         div_frac_i = 4'($urandom);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
